// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - funct encodings, mul/div FSM states and decode helpers for ex_muldiv.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    MFHI  = 6'h10,
    MTHI  = 6'h11,
    MFLO  = 6'h12,
    MTLO  = 6'h13,
    MULT  = 6'h18,
    MULTU = 6'h19,
    DIV   = 6'h1A,
    DIVU  = 6'h1B
  } funct_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } muldiv_state_t;

  localparam int MD_ITER = 32;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == MULT) || (f == MULTU) || (f == DIV) || (f == DIVU);
  endfunction

  function automatic logic is_hilo(input logic [5:0] f);
    return (f == MFHI) || (f == MTHI) || (f == MFLO) || (f == MTLO);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational mul/div iteration on the {upper,lower} accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               mbit_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] sum;

  always_comb begin
    rem_sh = '0;
    diff   = '0;
    sum    = '0;
    acc_o  = acc_i;
    if (is_div_i) begin
      // Restoring divide: upper half is the partial remainder, lower half collects quotient bits.
      rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
      diff   = rem_sh - {1'b0, opb_i};
      if (diff[WIDTH]) begin
        acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (mbit_i ? {1'b0, opb_i} : {(WIDTH+1){1'b0}});
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative EX-stage multiply/divide unit owning HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module ex_muldiv
  import cpu_types_pkg::*;
#(
  parameter int ITER  = MD_ITER,
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             valid_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rdat1_i,
  input  logic [WIDTH-1:0] rdat2_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] mfdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  localparam int CW = $clog2(ITER);

  muldiv_state_t      state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quo_mag, rem_mag, quo, rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .mbit_i   (mplier_q[0]),
    .acc_o    (step_acc)
  );

  assign is_signed = (funct_i == MULT) || (funct_i == DIV);
  assign a_neg     = is_signed & rdat1_i[WIDTH-1];
  assign b_neg     = is_signed & rdat2_i[WIDTH-1];
  assign a_mag     = a_neg ? -rdat1_i : rdat1_i;
  assign b_mag     = b_neg ? -rdat2_i : rdat2_i;

`ifdef MULDIV_EARLY_OUT_EN
  // An early exit leaves the product short of its remaining right shifts; finish them here.
  logic [CW-1:0] shamt;
  assign shamt    = CW'(ITER - 1) - count_q;
  assign prod_mag = acc_q >> shamt;
`else
  assign prod_mag = acc_q;
`endif

  assign prod    = neg_lo_q ? -prod_mag : prod_mag;
  assign quo_mag = acc_q[WIDTH-1:0];
  assign rem_mag = acc_q[2*WIDTH-1:WIDTH];
  // Divide by zero leaves |dividend| in the remainder, so sign correction restores rdat1 as latched.
  assign quo     = dz_q ? {WIDTH{1'b1}} : (neg_lo_q ? -quo_mag : quo_mag);
  assign rem     = neg_hi_q ? -rem_mag : rem_mag;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    mplier_d = mplier_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          if (is_muldiv(funct_i)) begin
            state_d  = CALC;
            count_d  = '0;
            is_div_d = (funct_i == DIV) || (funct_i == DIVU);
            if ((funct_i == DIV) || (funct_i == DIVU)) begin
              acc_d    = {{WIDTH{1'b0}}, a_mag};
              opb_d    = b_mag;
              mplier_d = '0;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = a_neg;
              dz_d     = (rdat2_i == '0);
            end else begin
              acc_d    = '0;
              opb_d    = a_mag;
              mplier_d = b_mag;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = a_neg ^ b_neg;
              dz_d     = 1'b0;
            end
          end else if (funct_i == MTHI) begin
            hi_d = rdat1_i;
          end else if (funct_i == MTLO) begin
            lo_d = rdat1_i;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          acc_d    = step_acc;
          mplier_d = mplier_q >> 1;
          if (count_q == CW'(ITER - 1)) begin
            state_d = SIGN;
`ifdef MULDIV_EARLY_OUT_EN
          end else if (!is_div_q && (mplier_q[WIDTH-1:1] == '0)) begin
            state_d = SIGN;
`endif
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      SIGN: begin
        state_d = IDLE;
        count_d = '0;
        if (!flush_i) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      mplier_q <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      mplier_q <= mplier_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign done_o   = done_q;
  assign busy_o   = (state_q != IDLE);
  assign stall_o  = busy_o & valid_i & (is_muldiv(funct_i) | is_hilo(funct_i));
  assign mfdata_o = (funct_i == MFHI) ? hi_q : ((funct_i == MFLO) ? lo_q : '0);

endmodule
